// File: rtl/sparc_tlu_ccrstk_pkg.sv
// Shared TLU constants for the trap-state CCR stack: depth, TL width and CCR layout.
package sparc_tlu_ccrstk_pkg;
    localparam int MAXTL_DEF = 6;
    localparam int TLW_DEF   = 3;
    localparam int NTHR      = 4;
    localparam int CCR_W     = 8;

    // CCR layout as presented by the EXU: {xcc, icc}
    localparam int CCR_XCC_MSB = 7;
    localparam int CCR_XCC_LSB = 4;
    localparam int CCR_ICC_MSB = 3;
    localparam int CCR_ICC_LSB = 0;

    function automatic logic [CCR_W-1:0] ccr_pack(input logic [3:0] xcc, input logic [3:0] icc);
        return {xcc, icc};
    endfunction
endpackage

// File: rtl/sparc_tlu_ccrstk_thr.sv
// One thread's TL counter and CCR stack entries 1..MAXTL with saturating push/pop.
module sparc_tlu_ccrstk_thr
    import sparc_tlu_ccrstk_pkg::*;
#(
    parameter int MAXTL = MAXTL_DEF,
    parameter int TLW   = TLW_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             wr_i,
    input  logic [CCR_W-1:0] push_data_i,
    input  logic [CCR_W-1:0] wr_data_i,
    output logic [TLW-1:0]   tl_o,
    output logic [CCR_W-1:0] top_o,
    output logic             ovf_o,
    output logic             unf_o
);
    logic [TLW-1:0]   tl_q;
    logic [CCR_W-1:0] ent_q [1:MAXTL];
    logic             tl_zero;
    logic             tl_max;
    logic [TLW-1:0]   push_idx;

    assign tl_zero  = (tl_q == '0);
    assign tl_max   = (tl_q == TLW'(MAXTL));
    // At full depth a push overwrites the top instead of growing the stack
    assign push_idx = tl_max ? tl_q : tl_q + 1'b1;

    assign tl_o  = tl_q;
    assign top_o = tl_zero ? '0 : ent_q[tl_q];
    assign ovf_o = push_i && tl_max;
    assign unf_o = pop_i && tl_zero;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tl_q <= '0;
            for (int i = 1; i <= MAXTL; i++) ent_q[i] <= '0;
        end else if (push_i) begin
            ent_q[push_idx] <= push_data_i;
            tl_q            <= push_idx;
        end else begin
            // A write and a pop together update the pre-pop top, then drop TL
            if (wr_i && !tl_zero) ent_q[tl_q] <= wr_data_i;
            if (pop_i && !tl_zero) tl_q <= tl_q - 1'b1;
        end
    end
endmodule

// File: rtl/sparc_tlu_ccrstk.sv
// Per-thread TSTATE.CCR stack: trap capture, DONE/RETRY restore to the EXU, WRPR/RDPR access.
module sparc_tlu_ccrstk
    import sparc_tlu_ccrstk_pkg::*;
#(
    parameter int MAXTL = MAXTL_DEF,
    parameter int TLW   = TLW_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CCR_W-1:0] exu_tlu_ccr0_w,
    input  logic [CCR_W-1:0] exu_tlu_ccr1_w,
    input  logic [CCR_W-1:0] exu_tlu_ccr2_w,
    input  logic [CCR_W-1:0] exu_tlu_ccr3_w,
    input  logic             trap_vld_w,
    input  logic [1:0]       trap_tid_w,
    input  logic             dnrtry_vld_e,
    input  logic [1:0]       dnrtry_tid_e,
    input  logic             ifu_exu_kill_e,
    input  logic             wrccr_vld_w,
    input  logic [1:0]       wrccr_tid_w,
    input  logic [CCR_W-1:0] wrccr_data_w,
    input  logic [1:0]       rdccr_tid_e,
    output logic             tlu_exu_cwpccr_update_m,
    output logic [CCR_W-1:0] tlu_exu_ccr_m,
    output logic [CCR_W-1:0] tlu_rdccr_m,
    output logic [TLW-1:0]   tlu_tl_thr0,
    output logic [TLW-1:0]   tlu_tl_thr1,
    output logic [TLW-1:0]   tlu_tl_thr2,
    output logic [TLW-1:0]   tlu_tl_thr3,
    output logic             tlu_ccrstk_ovf,
    output logic             tlu_ccrstk_unf
);
    logic [CCR_W-1:0] ccr_w [NTHR];
    logic [CCR_W-1:0] top   [NTHR];
    logic [TLW-1:0]   tl    [NTHR];
    logic [NTHR-1:0]  push, pop, wr, ovf, unf, tl_nz;

    logic             update_d, update_q;
    logic [CCR_W-1:0] ccr_d, ccr_q;
    logic [CCR_W-1:0] rdccr_d, rdccr_q;
    logic             ovf_q, unf_q;

    assign ccr_w[0] = exu_tlu_ccr0_w;
    assign ccr_w[1] = exu_tlu_ccr1_w;
    assign ccr_w[2] = exu_tlu_ccr2_w;
    assign ccr_w[3] = exu_tlu_ccr3_w;

    for (genvar t = 0; t < NTHR; t++) begin : g_thr
        // A trap on the same thread flushes the DONE/RETRY and wins over WRPR
        assign push[t]  = trap_vld_w && (trap_tid_w == 2'(t));
        assign pop[t]   = dnrtry_vld_e && !ifu_exu_kill_e && (dnrtry_tid_e == 2'(t)) && !push[t];
        assign wr[t]    = wrccr_vld_w && (wrccr_tid_w == 2'(t)) && !push[t];
        assign tl_nz[t] = (tl[t] != '0);

        sparc_tlu_ccrstk_thr #(.MAXTL(MAXTL), .TLW(TLW)) u_thr (
            .clk         (clk),
            .rst         (rst),
            .push_i      (push[t]),
            .pop_i       (pop[t]),
            .wr_i        (wr[t]),
            .push_data_i (ccr_w[t]),
            .wr_data_i   (wrccr_data_w),
            .tl_o        (tl[t]),
            .top_o       (top[t]),
            .ovf_o       (ovf[t]),
            .unf_o       (unf[t])
        );
    end

    // Restore data is the pre-write, pre-pop top of the DONE/RETRY thread
    assign update_d = |(pop & tl_nz);
    assign ccr_d    = update_d ? top[dnrtry_tid_e] : ccr_q;
    assign rdccr_d  = top[rdccr_tid_e];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            update_q <= 1'b0;
            ccr_q    <= '0;
            rdccr_q  <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            update_q <= update_d;
            ccr_q    <= ccr_d;
            rdccr_q  <= rdccr_d;
            ovf_q    <= |ovf;
            unf_q    <= |unf;
        end
    end

    assign tlu_exu_cwpccr_update_m = update_q;
    assign tlu_exu_ccr_m           = ccr_q;
    assign tlu_rdccr_m             = rdccr_q;
    assign tlu_ccrstk_ovf          = ovf_q;
    assign tlu_ccrstk_unf          = unf_q;
    assign tlu_tl_thr0             = tl[0];
    assign tlu_tl_thr1             = tl[1];
    assign tlu_tl_thr2             = tl[2];
    assign tlu_tl_thr3             = tl[3];
endmodule
